// File: rtl/periph_mailbox.sv
// periph_mailbox: peripheral-side responder for the core's 2-bit peripheral port.
// Holds an OUT FIFO (core -> host) and an IN FIFO (host -> core).
// Command opcodes: 00 NOP, 01 WRITE, 10 READ, 11 STATUS.
// Response codes:  00 none, 01 ACK, 10 DATA, 11 ERR.
// Optional feature macro: PERIPH_MBOX_STATUS_EN. When defined, STATUS returns a
// snapshot word and dropped commands are tracked in a sticky bit. When undefined,
// STATUS answers ERR and the sticky bit does not exist.
module periph_mailbox #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int RESP_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  input  logic                  host_wr_valid,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ready,
  output logic                  host_rd_valid,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  input  logic                  host_rd_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_ST  = 2'b11;

  localparam logic [1:0] RC_NONE = 2'b00;
  localparam logic [1:0] RC_ACK  = 2'b01;
  localparam logic [1:0] RC_DATA = 2'b10;
  localparam logic [1:0] RC_ERR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [LW-1:0]         r_lat_cnt;
  logic [1:0]            r_pend_code;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic [1:0]            r_rsp_code;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_valid;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_in_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_out_mem [DEPTH];
  logic [AW-1:0]         r_in_wr, r_in_rd, r_out_wr, r_out_rd;
  logic [CW-1:0]         r_in_cnt, r_out_cnt;

  logic w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic w_cmd, w_cap;
  logic w_core_push, w_core_pop, w_host_push, w_host_pop;
  logic [1:0]            w_res_code;
  logic [DATA_WIDTH-1:0] w_res_data;

  assign w_in_full   = (r_in_cnt  == CW'(DEPTH));
  assign w_in_empty  = (r_in_cnt  == '0);
  assign w_out_full  = (r_out_cnt == CW'(DEPTH));
  assign w_out_empty = (r_out_cnt == '0);

  // A command is anything valid except NOP; it is only taken while idle.
  assign w_cmd = to_peripheral_valid && (to_peripheral != OP_NOP);
  assign w_cap = (r_state == S_IDLE) && w_cmd;

  assign w_core_push = w_cap && (to_peripheral == OP_WR) && !w_out_full;
  assign w_core_pop  = w_cap && (to_peripheral == OP_RD) && !w_in_empty;
  // Full-ness uses the registered count, so a same-cycle pop never frees a slot.
  assign w_host_push = host_wr_valid && !w_in_full;
  assign w_host_pop  = host_rd_ready && !w_out_empty;

  // Host-facing outputs are pure decodes of state registers (no input paths).
  assign host_wr_ready = !w_in_full;
  assign host_rd_valid = !w_out_empty;
  assign host_rd_data  = w_out_empty ? '0 : r_out_mem[r_out_rd];

  assign from_peripheral       = r_rsp_code;
  assign from_peripheral_data  = r_rsp_data;
  assign from_peripheral_valid = r_rsp_valid;

`ifdef PERIPH_MBOX_STATUS_EN
  logic        r_drop;
  logic [31:0] w_status;
  assign w_status = {r_drop, w_in_empty, w_out_full, 13'd0, 8'(r_out_cnt), 8'(r_in_cnt)};
`endif

  // Result of the presented command, evaluated against pre-capture FIFO state.
  always_comb begin
    w_res_code = RC_ERR;
    w_res_data = '0;
    case (to_peripheral)
      OP_WR: if (!w_out_full) w_res_code = RC_ACK;
      OP_RD: if (!w_in_empty) begin
        w_res_code = RC_DATA;
        w_res_data = r_in_mem[r_in_rd];
      end
`ifdef PERIPH_MBOX_STATUS_EN
      OP_ST: begin
        w_res_code = RC_DATA;
        w_res_data = DATA_WIDTH'(w_status);
      end
`endif
      default: ;
    endcase
  end

  // Command FSM: capture in IDLE, count latency in WAIT, strobe one cycle in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lat_cnt   <= '0;
      r_pend_code <= RC_NONE;
      r_pend_data <= '0;
      r_rsp_code  <= RC_NONE;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
`ifdef PERIPH_MBOX_STATUS_EN
      r_drop      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_cap) begin
          r_pend_code <= w_res_code;
          r_pend_data <= w_res_data;
          r_lat_cnt   <= LW'(RESP_LATENCY - 1);
`ifdef PERIPH_MBOX_STATUS_EN
          if (to_peripheral == OP_ST) r_drop <= 1'b0;
`endif
          if (RESP_LATENCY == 1) begin
            r_state     <= S_RESP;
            r_rsp_code  <= w_res_code;
            r_rsp_data  <= w_res_data;
            r_rsp_valid <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (r_lat_cnt == LW'(1)) begin
            r_state     <= S_RESP;
            r_rsp_code  <= r_pend_code;
            r_rsp_data  <= r_pend_data;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_code  <= RC_NONE;
          r_rsp_data  <= '0;
          r_rsp_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef PERIPH_MBOX_STATUS_EN
      // Commands arriving while busy are discarded but remembered.
      if ((r_state != S_IDLE) && w_cmd) r_drop <= 1'b1;
`endif
    end
  end

  // FIFO storage writes; contents need no reset since counts gate visibility.
  always_ff @(posedge clock) begin
    if (w_host_push) r_in_mem[r_in_wr]   <= host_wr_data;
    if (w_core_push) r_out_mem[r_out_wr] <= to_peripheral_data;
  end

  // IN FIFO pointers and occupancy (host pushes, core pops).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_host_push) r_in_wr <= r_in_wr + 1'b1;
      if (w_core_pop)  r_in_rd <= r_in_rd + 1'b1;
      case ({w_host_push, w_core_pop})
        2'b10:   r_in_cnt <= r_in_cnt + CW'(1);
        2'b01:   r_in_cnt <= r_in_cnt - CW'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  // OUT FIFO pointers and occupancy (core pushes, host pops).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_core_push) r_out_wr <= r_out_wr + 1'b1;
      if (w_host_pop)  r_out_rd <= r_out_rd + 1'b1;
      case ({w_core_push, w_host_pop})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_mailbox.sv
// Directed bench for periph_mailbox: one latency-1 instance, plus latency-3 and
// latency-4 instances sharing one stimulus group.
module tb_periph_mailbox;

  localparam logic [1:0] WR = 2'd1, RD = 2'd2, ST = 2'd3;
  localparam logic [1:0] ACK = 2'd1, DAT = 2'd2, ERR = 2'd3;
`ifdef PERIPH_MBOX_STATUS_EN
  localparam bit ST_ON = 1'b1;
`else
  localparam bit ST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // latency-1 instance
  logic        rst = 1'b1;
  logic [1:0]  a_op = '0;
  logic [31:0] a_d = '0;
  logic        a_v = 1'b0;
  logic [1:0]  a_fp;
  logic [31:0] a_fd;
  logic        a_fv;
  logic        a_hwv = 1'b0;
  logic [31:0] a_hwd = '0;
  logic        a_hwr;
  logic        a_hrv;
  logic [31:0] a_hrd;
  logic        a_hrr = 1'b0;

  periph_mailbox #(.DATA_WIDTH(32), .DEPTH(8), .RESP_LATENCY(1)) u1 (
    .clock(clk), .reset(rst),
    .to_peripheral(a_op), .to_peripheral_data(a_d), .to_peripheral_valid(a_v),
    .from_peripheral(a_fp), .from_peripheral_data(a_fd), .from_peripheral_valid(a_fv),
    .host_wr_valid(a_hwv), .host_wr_data(a_hwd), .host_wr_ready(a_hwr),
    .host_rd_valid(a_hrv), .host_rd_data(a_hrd), .host_rd_ready(a_hrr));

  // shared stimulus for latency-3 and latency-4 instances
  logic        rb = 1'b1;
  logic [1:0]  b_op = '0;
  logic [31:0] b_d = '0;
  logic        b_v = 1'b0;
  logic        b_hwv = 1'b0;
  logic [31:0] b_hwd = '0;
  logic        b_hrr = 1'b0;
  logic [1:0]  b3_fp, b4_fp;
  logic [31:0] b3_fd, b4_fd;
  logic        b3_fv, b4_fv;
  logic        b3_hwr, b4_hwr, b3_hrv, b4_hrv;
  logic [31:0] b3_hrd, b4_hrd;

  periph_mailbox #(.DATA_WIDTH(32), .DEPTH(8), .RESP_LATENCY(3)) u3 (
    .clock(clk), .reset(rb),
    .to_peripheral(b_op), .to_peripheral_data(b_d), .to_peripheral_valid(b_v),
    .from_peripheral(b3_fp), .from_peripheral_data(b3_fd), .from_peripheral_valid(b3_fv),
    .host_wr_valid(b_hwv), .host_wr_data(b_hwd), .host_wr_ready(b3_hwr),
    .host_rd_valid(b3_hrv), .host_rd_data(b3_hrd), .host_rd_ready(b_hrr));

  periph_mailbox #(.DATA_WIDTH(32), .DEPTH(8), .RESP_LATENCY(4)) u4 (
    .clock(clk), .reset(rb),
    .to_peripheral(b_op), .to_peripheral_data(b_d), .to_peripheral_valid(b_v),
    .from_peripheral(b4_fp), .from_peripheral_data(b4_fd), .from_peripheral_valid(b4_fv),
    .host_wr_valid(b_hwv), .host_wr_data(b_hwd), .host_wr_ready(b4_hwr),
    .host_rd_valid(b4_hrv), .host_rd_data(b4_hrd), .host_rd_ready(b_hrr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge; return at the falling edge after its sample.
  task automatic a_cmd(input logic [1:0] op, input logic [31:0] d);
    a_op = op; a_d = d; a_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_v = 1'b0; a_op = '0; a_d = '0;
  endtask

  task automatic b_cmd(input logic [1:0] op, input logic [31:0] d);
    b_op = op; b_d = d; b_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_v = 1'b0; b_op = '0; b_d = '0;
  endtask

  // Bounded wait for a response strobe from instance 3 or 4.
  task automatic wait_b(input int sel, output logic seen, output logic [1:0] c, output logic [31:0] d);
    seen = 1'b0; c = '0; d = '0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if ((sel == 3) ? b3_fv : b4_fv) begin
        seen = 1'b1;
        c = (sel == 3) ? b3_fp : b4_fp;
        d = (sel == 3) ? b3_fd : b4_fd;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [1:0]  c;
    logic [31:0] d;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    chk("rst_fp",   32'(a_fp), 0);
    chk("rst_fd",   a_fd, 0);
    chk("rst_fv",   32'(a_fv), 0);
    chk("rst_hwr",  32'(a_hwr), 1);
    chk("rst_hrv",  32'(a_hrv), 0);
    chk("rst_hrd",  a_hrd, 0);
    rst = 1'b0; rb = 1'b0;
    @(negedge clk);

    // ---------------- host push then core READ
    a_hwv = 1'b1; a_hwd = 32'hA5A5_0001;
    @(negedge clk);
    a_hwv = 1'b0;
    a_cmd(RD, 0);
    chk("rd1_fv", 32'(a_fv), 1);
    chk("rd1_fp", 32'(a_fp), 32'(DAT));
    chk("rd1_fd", a_fd, 32'hA5A5_0001);
    @(negedge clk);
    chk("rd1_strobe_off_fv", 32'(a_fv), 0);
    chk("rd1_strobe_off_fp", 32'(a_fp), 0);
    chk("rd1_strobe_off_fd", a_fd, 0);

    // ---------------- READ with IN empty
    a_cmd(RD, 0);
    chk("rd_empty_fp", 32'(a_fp), 32'(ERR));
    chk("rd_empty_fd", a_fd, 0);
    @(negedge clk);

    // ---------------- fill OUT with eight WRITEs, then a ninth
    for (int i = 0; i < 8; i++) begin
      a_cmd(WR, 32'h1234_5678 + i);
      chk("wr_ack_fp", 32'(a_fp), 32'(ACK));
      chk("wr_ack_fd", a_fd, 0);
      if (i == 0) begin
        chk("wr_first_hrv", 32'(a_hrv), 1);
        chk("wr_first_hrd", a_hrd, 32'h1234_5678);
      end
      @(negedge clk);
    end
    a_cmd(WR, 32'hDEAD_BEEF);
    chk("wr_full_fp", 32'(a_fp), 32'(ERR));
    chk("wr_full_fd", a_fd, 0);
    @(negedge clk);
    chk("out_head_hrd", a_hrd, 32'h1234_5678);

    // ---------------- host drains OUT in order
    for (int i = 0; i < 8; i++) begin
      chk("pop_hrv", 32'(a_hrv), 1);
      chk("pop_hrd", a_hrd, 32'h1234_5678 + i);
      a_hrr = 1'b1;
      @(negedge clk);
    end
    a_hrr = 1'b0;
    chk("pop_done_hrv", 32'(a_hrv), 0);
    chk("pop_done_hrd", a_hrd, 0);

    // ---------------- STATUS on empty mailbox
    a_cmd(ST, 0);
    chk("st_empty_fp", 32'(a_fp), ST_ON ? 32'(DAT) : 32'(ERR));
    chk("st_empty_fd", a_fd, ST_ON ? 32'h4000_0000 : 32'h0);
    @(negedge clk);

    // ---------------- fill IN, then host push and core READ together
    for (int i = 0; i < 8; i++) begin
      a_hwv = 1'b1; a_hwd = 32'h100 + i;
      @(negedge clk);
    end
    a_hwd = 32'h0000_0BAD;
    chk("in_full_hwr", 32'(a_hwr), 0);
    a_cmd(RD, 0);
    a_hwv = 1'b0;
    chk("in_full_rd_fp", 32'(a_fp), 32'(DAT));
    chk("in_full_rd_fd", a_fd, 32'h100);
    chk("in_7_hwr", 32'(a_hwr), 1);
    @(negedge clk);
    a_cmd(ST, 0);
    chk("st_in7_fd", a_fd, ST_ON ? 32'h0000_0007 : 32'h0);
    @(negedge clk);
    for (int i = 1; i < 8; i++) begin
      a_cmd(RD, 0);
      chk("in_drain_fd", a_fd, 32'h100 + i);
      @(negedge clk);
    end
    a_cmd(RD, 0);
    chk("in_refused_fp", 32'(a_fp), 32'(ERR));
    @(negedge clk);

    // ---------------- latency 3: second WRITE one cycle later is dropped
    b_op = WR; b_d = 32'h1111_1111; b_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("l3_c1_fv", 32'(b3_fv), 0);
    b_d = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    b_v = 1'b0; b_op = '0; b_d = '0;
    chk("l3_c2_fv", 32'(b3_fv), 0);
    @(negedge clk);
    chk("l3_c3_fv", 32'(b3_fv), 1);
    chk("l3_c3_fp", 32'(b3_fp), 32'(ACK));
    chk("l3_c3_fd", b3_fd, 0);
    chk("l4_c3_fv", 32'(b4_fv), 0);
    @(negedge clk);
    chk("l3_c4_fv", 32'(b3_fv), 0);
    chk("l4_c4_fv", 32'(b4_fv), 1);
    chk("l4_c4_fp", 32'(b4_fp), 32'(ACK));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("l3_no_second_ack", 32'(b3_fv), 0);
      chk("l4_no_second_ack", 32'(b4_fv), 0);
    end
    chk("l3_out_hrv", 32'(b3_hrv), 1);
    chk("l3_out_hrd", b3_hrd, 32'h1111_1111);

    b_cmd(ST, 0);
    wait_b(3, seen, c, d);
    chk("l3_st1_seen", 32'(seen), 1);
    chk("l3_st1_fp", 32'(c), ST_ON ? 32'(DAT) : 32'(ERR));
    chk("l3_st1_fd", d, ST_ON ? 32'hC000_0100 : 32'h0);
    repeat (3) @(negedge clk);
    b_cmd(ST, 0);
    wait_b(3, seen, c, d);
    chk("l3_st2_seen", 32'(seen), 1);
    chk("l3_st2_fd", d, ST_ON ? 32'h4000_0100 : 32'h0);
    repeat (3) @(negedge clk);

    // ---------------- latency 4: reset during WAIT
    b_cmd(WR, 32'h3333_3333);
    @(negedge clk);
    rb = 1'b1;
    #1;
    chk("l4_rst_fv", 32'(b4_fv), 0);
    @(negedge clk);
    rb = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("l4_post_rst_fv", 32'(b4_fv), 0);
    end
    chk("l4_post_rst_hrv", 32'(b4_hrv), 0);
    chk("l4_post_rst_hrd", b4_hrd, 0);
    chk("l4_post_rst_hwr", 32'(b4_hwr), 1);
    b_cmd(RD, 0);
    wait_b(4, seen, c, d);
    chk("l4_rd_seen", 32'(seen), 1);
    chk("l4_rd_empty_fp", 32'(c), 32'(ERR));
    chk("l4_rd_empty_fd", d, 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
